mat_key_scan_ev: RTL and testbench

//  Parametrised ROWSxCOLS matrix-keypad scanner: one-cold row drive, per-key debounce, level outputs.

---
 rtl/mat_key_pkg.sv | 16 +
 rtl/key_ev_fifo.sv | 52 +++++
 rtl/mat_key_scan_ev.sv | 150 +++++++++++++++
 tb/tb_mat_key_scan_ev.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_key_pkg.sv
// Shared defaults and the key-event record for the matrix keypad scanner.
package mat_key_pkg;

  localparam int ROWS_DEF        = 4;
  localparam int COLS_DEF        = 4;
  localparam int SCAN_DIV_DEF    = 8;
  localparam int DEB_SAMPLES_DEF = 8;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int KW_DEF          = $clog2(ROWS_DEF * COLS_DEF);

  typedef struct packed {
    logic              press;
    logic [KW_DEF-1:0] key;
  } key_ev_t;

endpackage

// File: rtl/key_ev_fifo.sv
// Small valid/ready event FIFO; a push into a full FIFO is accepted when a pop
// frees a slot on the same cycle, otherwise it is dropped and flagged.
module key_ev_fifo
  import mat_key_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = $bits(key_ev_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic             pop_valid_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, empty, pop, push_ok;

  assign full        = (count_q == (AW+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign pop         = !empty && pop_ready_i;
  assign push_ok     = push_i && (!full || pop);
  assign drop_o      = push_i && full && !pop;
  assign pop_valid_o = !empty;
  assign pop_data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push_ok && pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mat_key_scan_ev.sv
// Matrix keypad scanner: one-cold row drive, per-key frame debounce, level outputs
// and a press/release event stream delivered through a small FIFO.
module mat_key_scan_ev
  import mat_key_pkg::*;
#(
  parameter  int ROWS        = ROWS_DEF,
  parameter  int COLS        = COLS_DEF,
  parameter  int SCAN_DIV    = SCAN_DIV_DEF,
  parameter  int DEB_SAMPLES = DEB_SAMPLES_DEF,
  parameter  int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  localparam int KW          = $clog2(ROWS * COLS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COLS-1:0]      col_in,
  output logic [ROWS-1:0]      row_out,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 frame_sync,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic                 ev_press,
  output logic [KW-1:0]        ev_key,
  output logic                 ev_overflow,
  input  logic                 ovf_clr
);

  localparam int NK = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(SCAN_DIV);

  logic [COLS-1:0]        sync1_q, sync2_q;
  logic [CW-1:0]          dwell_q;
  logic [RW-1:0]          row_q;
  logic [COLS-1:0]        sample_q [ROWS];
  logic                   frame_end_q;
  logic [DEB_SAMPLES-1:0] hist_q [NK];
  logic [DEB_SAMPLES-1:0] hist_d [NK];
  logic [NK-1:0]          key_state_q, key_state_d;
  logic [NK-1:0]          pending_q, pending_d;
  logic                   walk_active_q, walk_active_d;
  logic [KW-1:0]          walk_idx_q, walk_idx_d;
  logic                   ev_overflow_q;
  logic                   push;
  logic [KW:0]            push_data, head_data;
  logic                   drop;

  // Sample row r at the end of its dwell; frame_end_q flags the cycle after row ROWS-1 is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      dwell_q     <= '0;
      row_q       <= '0;
      frame_end_q <= 1'b0;
      for (int r = 0; r < ROWS; r++) sample_q[r] <= '0;
    end else begin
      sync1_q     <= col_in;
      sync2_q     <= sync1_q;
      frame_end_q <= 1'b0;
      if (dwell_q == CW'(SCAN_DIV - 1)) begin
        dwell_q         <= '0;
        sample_q[row_q] <= sync2_q;
        row_q           <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        frame_end_q     <= (row_q == RW'(ROWS - 1));
      end else begin
        dwell_q <= dwell_q + CW'(1);
      end
    end
  end

  always_comb begin
    row_out = '1;
    for (int r = 0; r < ROWS; r++) row_out[ROWS-1-r] = (row_q != RW'(r));
  end

  assign frame_sync = (row_q == RW'(ROWS - 1));

  always_comb begin
    key_state_d = key_state_q;
    for (int k = 0; k < NK; k++) begin
      hist_d[k] = hist_q[k];
      if (frame_end_q) begin
        hist_d[k] = {hist_q[k][DEB_SAMPLES-2:0], sample_q[k / COLS][k % COLS]};
        if (&hist_d[k])      key_state_d[k] = 1'b1;
        else if (~|hist_d[k]) key_state_d[k] = 1'b0;
      end
    end
  end

  // The walker visits one key per cycle; a new frame restarts it and adds fresh changes.
  always_comb begin
    pending_d     = pending_q;
    walk_active_d = walk_active_q;
    walk_idx_d    = walk_idx_q;
    push          = 1'b0;
    push_data     = {key_state_q[walk_idx_q], walk_idx_q};
    if (walk_active_q) begin
      if (pending_q[walk_idx_q]) begin
        push                  = 1'b1;
        pending_d[walk_idx_q] = 1'b0;
      end
      if (walk_idx_q == KW'(NK - 1)) walk_active_d = 1'b0;
      else                           walk_idx_d    = walk_idx_q + KW'(1);
    end
    if (frame_end_q) begin
      pending_d     = pending_d | (key_state_d ^ key_state_q);
      walk_active_d = 1'b1;
      walk_idx_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state_q   <= '0;
      pending_q     <= '0;
      walk_active_q <= 1'b0;
      walk_idx_q    <= '0;
      ev_overflow_q <= 1'b0;
      for (int k = 0; k < NK; k++) hist_q[k] <= '0;
    end else begin
      key_state_q   <= key_state_d;
      pending_q     <= pending_d;
      walk_active_q <= walk_active_d;
      walk_idx_q    <= walk_idx_d;
      for (int k = 0; k < NK; k++) hist_q[k] <= hist_d[k];
      if (drop)         ev_overflow_q <= 1'b1;
      else if (ovf_clr) ev_overflow_q <= 1'b0;
    end
  end

  key_ev_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KW + 1)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_ready_i (ev_ready),
    .pop_valid_o (ev_valid),
    .pop_data_o  (head_data),
    .drop_o      (drop)
  );

  assign key_state   = key_state_q;
  assign ev_press    = head_data[KW];
  assign ev_key      = head_data[KW-1:0];
  assign ev_overflow = ev_overflow_q;

endmodule

// File: tb/tb_mat_key_scan_ev.sv
// Bench for mat_key_scan_ev: keypad matrix stimulus with a frame-level debounce
// and event-queue reference model, plus literal pins at known cycles.
module tb_mat_key_scan_ev;

  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEB = 4, DEPTH = 4;
  localparam int NK = ROWS * COLS, FRAME = ROWS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_in = '0;
  logic [3:0]  row_out;
  logic [15:0] key_state;
  logic        frame_sync, ev_valid, ev_press, ev_overflow;
  logic        ev_ready = 1'b1;
  logic        ovf_clr = 1'b0;
  logic [3:0]  ev_key;

  always #5 clk = ~clk;

  mat_key_scan_ev #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_SAMPLES(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out), .key_state(key_state),
    .frame_sync(frame_sync), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_press(ev_press),
    .ev_key(ev_key), .ev_overflow(ev_overflow), .ovf_clr(ovf_clr)
  );

  typedef struct {
    bit press;
    int key;
  } ev_s;

  int         nEdge, checks, fails;
  bit         postReset;
  logic [3:0] matrix [ROWS];
  logic [3:0] frameM [ROWS];
  logic [3:0] randM  [ROWS];
  int         run1 [NK];
  int         run0 [NK];
  bit         mState [NK];
  bit         evDue [NK];
  int         walkBase;
  bit         mOvf;
  ev_s        mFifo [$];

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, nEdge, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NK; k++) begin
      run1[k] = 0; run0[k] = DEB; mState[k] = 0; evDue[k] = 0;
    end
    mFifo.delete();
    walkBase = 0;
    mOvf = 0;
  endtask

  // Reference behaviour at one rising edge: queue pop, scheduled event push, frame debounce.
  task automatic modelEdge();
    bit  pushNow, dropNow, s, newS;
    int  idx;
    ev_s e;
    pushNow = 0; dropNow = 0;
    e.press = 0; e.key = 0;
    if (mFifo.size() > 0 && ev_ready) mFifo.delete(0);
    if (walkBase > 0) begin
      idx = nEdge - walkBase - 1;
      if (idx >= 0 && idx < NK && evDue[idx]) begin
        pushNow = 1; e.press = mState[idx]; e.key = idx; evDue[idx] = 0;
      end
    end
    if (pushNow) begin
      if (mFifo.size() < DEPTH) mFifo.push_back(e);
      else dropNow = 1;
    end
    if (dropNow) mOvf = 1;
    else if (ovf_clr) mOvf = 0;
    if (nEdge % FRAME == 0) for (int r = 0; r < ROWS; r++) frameM[r] = matrix[r];
    if (nEdge % FRAME == 1 && nEdge > 1) begin
      for (int k = 0; k < NK; k++) begin
        s = frameM[k / COLS][k % COLS];
        if (s) begin run1[k]++; run0[k] = 0; end
        else   begin run0[k]++; run1[k] = 0; end
        newS = mState[k];
        if (run1[k] >= DEB) newS = 1;
        if (run0[k] >= DEB) newS = 0;
        if (newS != mState[k]) evDue[k] = 1;
        mState[k] = newS;
      end
      walkBase = nEdge;
    end
  endtask

  task automatic checkOutput();
    int          expRow;
    logic [3:0]  expRowOut;
    logic [15:0] expKs;
    expRow    = (nEdge / SCAN_DIV) % ROWS;
    expRowOut = ~(4'b1000 >> expRow);
    for (int k = 0; k < NK; k++) expKs[k] = mState[k];
    checkVal("row_out", int'(row_out), int'(expRowOut));
    checkVal("frame_sync", int'(frame_sync), int'(expRow == ROWS - 1));
    checkVal("key_state", int'(key_state), int'(expKs));
    checkVal("ev_valid", int'(ev_valid), int'(mFifo.size() > 0));
    checkVal("ev_overflow", int'(ev_overflow), int'(mOvf));
    if (mFifo.size() > 0) begin
      checkVal("ev_press", int'(ev_press), int'(mFifo[0].press));
      checkVal("ev_key", int'(ev_key), mFifo[0].key);
    end
  endtask

  task automatic resetChecks(input string tag);
    checkVal({tag, "_row_out"}, int'(row_out), 4'b0111);
    checkVal({tag, "_key_state"}, int'(key_state), 0);
    checkVal({tag, "_ev_valid"}, int'(ev_valid), 0);
    checkVal({tag, "_ev_overflow"}, int'(ev_overflow), 0);
    checkVal({tag, "_frame_sync"}, int'(frame_sync), 0);
  endtask

  // Hand-computed expectations that pin the model at known cycles.
  task automatic pinChecks();
    if (postReset) begin
      if (nEdge == 128) checkVal("pin_post_ks_before", int'(key_state), 0);
      if (nEdge == 129) checkVal("pin_post_ks_key5", int'(key_state), 16'h0020);
      if (nEdge == 135) checkVal("pin_post_ev_key5", int'(ev_key), 5);
      return;
    end
    if (nEdge == 8)    checkVal("pin_row1", int'(row_out), 4'b1011);
    if (nEdge == 31)   checkVal("pin_row3", int'(row_out), 4'b1110);
    if (nEdge == 31)   checkVal("pin_fsync_hi", int'(frame_sync), 1);
    if (nEdge == 32)   checkVal("pin_row0_wrap", int'(row_out), 4'b0111);
    if (nEdge == 32)   checkVal("pin_fsync_lo", int'(frame_sync), 0);
    if (nEdge == 128)  checkVal("pin_ks_pre6", int'(key_state), 0);
    if (nEdge == 129)  checkVal("pin_ks_6", int'(key_state), 16'h0040);
    if (nEdge == 136)  checkVal("pin_ev6_valid", int'(ev_valid), 1);
    if (nEdge == 136)  checkVal("pin_ev6_press", int'(ev_press), 1);
    if (nEdge == 136)  checkVal("pin_ev6_key", int'(ev_key), 6);
    if (nEdge == 257)  checkVal("pin_ks_rel6", int'(key_state), 0);
    if (nEdge == 264)  checkVal("pin_ev6_rel", int'(ev_press), 0);
    if (nEdge == 641)  checkVal("pin_toggle_ks", int'(key_state), 0);
    if (nEdge == 641)  checkVal("pin_toggle_noev", int'(ev_valid), 0);
    if (nEdge == 769)  checkVal("pin_ks_3_12", int'(key_state), 16'h1008);
    if (nEdge == 773)  checkVal("pin_ev3_key", int'(ev_key), 3);
    if (nEdge == 774)  checkVal("pin_ev3_popped", int'(ev_valid), 0);
    if (nEdge == 782)  checkVal("pin_ev12_key", int'(ev_key), 12);
    if (nEdge == 1036) checkVal("pin_ovf_before", int'(ev_overflow), 0);
    if (nEdge == 1037) checkVal("pin_ovf_set", int'(ev_overflow), 1);
    if (nEdge == 1037) checkVal("pin_full_head", int'(ev_key), 1);
    if (nEdge == 1101) checkVal("pin_ovf_clr", int'(ev_overflow), 0);
    if (nEdge == 1111) checkVal("pin_drain_2", int'(ev_key), 2);
    if (nEdge == 1113) checkVal("pin_drain_9", int'(ev_key), 9);
    if (nEdge == 1114) checkVal("pin_drain_empty", int'(ev_valid), 0);
  endtask

  task automatic setFrame(input int f);
    for (int r = 0; r < ROWS; r++) matrix[r] = '0;
    if (postReset) begin
      if (f < 4) matrix[1][1] = 1'b1;
    end else if (f < 4) begin
      matrix[1][2] = 1'b1;
    end else if (f >= 8 && f < 20) begin
      matrix[0][0] = (f % 2 == 0);
    end else if (f >= 20 && f < 24) begin
      matrix[0][3] = 1'b1; matrix[3][0] = 1'b1;
    end else if (f >= 28 && f < 34) begin
      matrix[0][1] = 1'b1; matrix[0][2] = 1'b1; matrix[1][1] = 1'b1;
      matrix[2][1] = 1'b1; matrix[2][3] = 1'b1;
    end else if (f >= 36) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if ($urandom_range(0, 5) == 0) randM[r][c] = ~randM[r][c];
      for (int r = 0; r < ROWS; r++) matrix[r] = randM[r];
    end
  endtask

  function automatic int decodeRow();
    for (int r = 0; r < ROWS; r++) if (row_out[ROWS-1-r] == 1'b0) return r;
    return 0;
  endfunction

  task automatic applyStimulus();
    if (nEdge % FRAME == 0 && nEdge > 0) setFrame(nEdge / FRAME);
    if (postReset) begin
      ev_ready = 1'b1;
      ovf_clr  = 1'b0;
    end else begin
      if (nEdge < 960 || (nEdge >= 1110 && nEdge < 1152)) ev_ready = 1'b1;
      else if (nEdge >= 1152 && nEdge < 2400)             ev_ready = ($urandom_range(0, 3) != 0);
      else                                                ev_ready = 1'b0;
      ovf_clr = (nEdge == 1100) || (nEdge >= 1152 && nEdge < 2400 && $urandom_range(0, 31) == 0);
    end
    col_in = matrix[decodeRow()];
  endtask

  task automatic runCycles(input int count);
    repeat (count) begin
      @(posedge clk);
      nEdge++;
      modelEdge();
      @(negedge clk);
      checkOutput();
      pinChecks();
      applyStimulus();
    end
  endtask

  initial begin
    checks = 0; fails = 0; nEdge = 0; postReset = 0;
    for (int r = 0; r < ROWS; r++) randM[r] = '0;
    modelReset();
    setFrame(0);
    col_in = matrix[0];
    repeat (3) @(negedge clk);
    $display("[TB] checking reset values");
    resetChecks("reset");
    rst_n = 1'b1;
    runCycles(76 * FRAME + 13);

    $display("[TB] asserting reset mid-frame");
    #2 rst_n = 1'b0;
    #1 resetChecks("midreset");
    postReset = 1;
    modelReset();
    setFrame(0);
    ev_ready = 1'b1;
    ovf_clr  = 1'b0;
    col_in   = matrix[0];
    @(negedge clk);
    @(negedge clk);
    resetChecks("held");
    rst_n = 1'b1;
    nEdge = 0;
    runCycles(5 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
